// File: rtl/bcd_freq_generator.sv
// bcd_freq_generator
//   Converts an 8-digit packed-BCD frequency setpoint to binary and generates
//   exactly that many one-cycle test pulses per CLK_HZ-cycle window, together
//   with a one-second strobe aligned to those windows.
// Ports
//   CLOCK_50    system clock, rising edge
//   reset       synchronous, active-high
//   load        one-cycle request to apply bcd_freq (ignored while busy)
//   bcd_freq    packed BCD setpoint, digit 0 in [3:0]
//   busy        conversion in progress
//   err         last load rejected (bad nibble or above CLK_HZ)
//   freq_bin    active setpoint in binary
//   test_pulse  generated pulse, one cycle wide
//   one_hz      one-cycle strobe every CLK_HZ cycles
module bcd_freq_generator #(
    parameter int  CLK_HZ = 50_000_000,
    parameter int  DIGITS = 8,
    localparam int ACC_W  = $clog2(CLK_HZ + 1) + 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_freq,
    output logic                  busy,
    output logic                  err,
    output logic [ACC_W-1:0]      freq_bin,
    output logic                  test_pulse,
    output logic                  one_hz
);
    // Conversion register is as wide as the BCD input: 10^D < 16^D, so even
    // a setpoint with bad nibbles cannot overflow it before the range check.
    localparam int CONV_W = 4 * DIGITS;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CONV_W-1:0] MAX_F = CONV_W'(CLK_HZ);
    localparam logic [ACC_W-1:0]  HZ_A  = ACC_W'(CLK_HZ);
    localparam logic [ACC_W-1:0]  LAST  = ACC_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {IDLE, CONV, CHECK} state_t;

    state_t             state, state_nxt;
    logic [CONV_W-1:0]  shadow;
    logic [CONV_W-1:0]  conv;
    logic [IDX_W-1:0]   idx;
    logic               bad;
    logic [3:0]         digit;
    logic               over;
    logic               cap_en, conv_en, commit, reject;
    logic [ACC_W-1:0]   acc, div, s;

    // Shadow shifts left each CONV cycle, so the current digit is always
    // the top nibble (MSB digit first).
    assign digit = shadow[CONV_W-1 -: 4];
    assign over  = bad || (conv > MAX_F);
    assign s     = acc + freq_bin;

    // FSM: state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONV;
            CONV:    if (idx == '0) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs / datapath strobes
    always_comb begin
        busy    = (state != IDLE);
        cap_en  = (state == IDLE) && load;
        conv_en = (state == CONV);
        commit  = (state == CHECK) && !over;
        reject  = (state == CHECK) && over;
    end

    // Sequential multiply-add: conv*10 + digit, with *10 as (x<<3)+(x<<1)
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            shadow <= '0;
            conv   <= '0;
            idx    <= '0;
            bad    <= 1'b0;
        end else if (cap_en) begin
            shadow <= bcd_freq;
            conv   <= '0;
            idx    <= IDX_W'(DIGITS - 1);
            bad    <= 1'b0;
        end else if (conv_en) begin
            conv   <= (conv << 3) + (conv << 1) + CONV_W'(digit);
            shadow <= shadow << 4;
            idx    <= idx - IDX_W'(1);
            if (digit > 4'd9) bad <= 1'b1;
        end
    end

    // Pulse engine and one-second divider. A commit restarts both from zero
    // so every later CLK_HZ window holds exactly freq_bin pulses: the
    // accumulator returns to 0 after CLK_HZ steps of +freq_bin mod CLK_HZ.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            freq_bin   <= '0;
            err        <= 1'b0;
            acc        <= '0;
            div        <= '0;
            test_pulse <= 1'b0;
            one_hz     <= 1'b0;
        end else if (commit) begin
            freq_bin   <= conv[ACC_W-1:0];
            err        <= 1'b0;
            acc        <= '0;
            div        <= '0;
            test_pulse <= 1'b0;
            one_hz     <= 1'b0;
        end else begin
            if (reject) err <= 1'b1;
            if (s >= HZ_A) begin
                acc        <= s - HZ_A;
                test_pulse <= 1'b1;
            end else begin
                acc        <= s;
                test_pulse <= 1'b0;
            end
            one_hz <= (div == LAST);
            div    <= (div == LAST) ? '0 : div + ACC_W'(1);
        end
    end

endmodule
